icache_refill_ctrl: RTL

- Miss handler between the CPU fetch/load port, the 4-way set-associative cache, and main memory.
- On a cache miss it stalls the CPU, fetches the word from memory over a valid/ready request and valid response interface, then writes it into the cache through the cache's `we`/`data_in` fill port.
- On a hit it passes cache data straight to the CPU with zero added latency.

---
 rtl/cache_pkg.sv | 26 ++
 rtl/icache_refill_ctrl_if.sv | 46 ++++
 rtl/sat_counter.sv | 24 ++
 rtl/icache_refill_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the instruction-cache refill path.
//   refill_state_t : miss-handler states (IDLE, REQ, WAIT, FILL)
//   DEFAULT_*      : default bus widths used by the interface and the top
//   word_align     : clears the byte offset of an address (4-byte words)
package cache_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH = 32;

  // word_align works on the widest address we support; callers cast in/out.
  localparam int MAX_ADDR_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FILL = 2'd3
  } refill_state_t;

  function automatic logic [MAX_ADDR_WIDTH-1:0] word_align(
    input logic [MAX_ADDR_WIDTH-1:0] addr
  );
    return {addr[MAX_ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Bus bundle around the refill controller: CPU fetch port, cache lookup/fill
// port and the memory request/response channels.
//   master : the refill controller side
//   slave  : the environment (CPU, cache array, memory)
interface icache_refill_ctrl_if
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  // CPU side
  logic                  cpu_req;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_data;
  logic                  stall;

  // Cache side
  logic                  cache_hit;
  logic [DATA_WIDTH-1:0] cache_data;
  logic [ADDR_WIDTH-1:0] cache_addr;
  logic                  fill_we;
  logic [DATA_WIDTH-1:0] fill_data;

  // Memory side
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_data;

  modport master (
    input  cpu_req, cpu_addr, cache_hit, cache_data,
           mem_req_ready, mem_resp_valid, mem_resp_data,
    output cpu_data, stall, cache_addr, fill_we, fill_data,
           mem_req_valid, mem_req_addr
  );

  modport slave (
    output cpu_req, cpu_addr, cache_hit, cache_data,
           mem_req_ready, mem_resp_valid, mem_resp_data,
    input  cpu_data, stall, cache_addr, fill_we, fill_data,
           mem_req_valid, mem_req_addr
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk, rst_n : clock, asynchronous active-low reset (clears count)
//   inc        : add one this cycle unless already at all-ones
//   count      : current value
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // NOTE: registers are written with non-blocking assignments so every flop
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler.
// A hit passes cache data to the CPU combinationally. A miss stalls the CPU in
// the same cycle, reads the word from memory (valid/ready request, valid-only
// response), writes it into the cache for one cycle, then lets the CPU replay
// the access, which now hits.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : icache_refill_ctrl_if.master (CPU, cache and memory signals)
//   miss_count : saturating number of misses seen since reset
//   mem_err    : sticky, set when a memory request timed out and was reissued
module icache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  icache_refill_ctrl_if.master bus,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic                 mem_err
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_REQ  = REQ;
  localparam logic [1:0] ST_WAIT = WAIT;
  localparam logic [1:0] ST_FILL = FILL;

  localparam int                     TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST  = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic [ADDR_WIDTH-1:0]  miss_addr;
  logic [DATA_WIDTH-1:0]  resp_buf;
  logic [TIMER_WIDTH-1:0] timer;

  logic miss_detect;
  logic req_fire;
  logic resp_take;
  logic timeout_hit;

  assign miss_detect = (state == ST_IDLE) && bus.cpu_req && !bus.cache_hit;
  assign req_fire    = (state == ST_REQ) && bus.mem_req_ready;
  assign resp_take   = (state == ST_WAIT) && bus.mem_resp_valid;
  // A response in the final timer cycle wins over the timeout.
  assign timeout_hit = (state == ST_WAIT) && !bus.mem_resp_valid && (timer == TIMER_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (miss_detect) state_nxt = ST_REQ;
      ST_REQ:  if (req_fire)    state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (resp_take)        state_nxt = ST_FILL;
        else if (timeout_hit) state_nxt = ST_REQ;
      end
      ST_FILL: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      miss_addr <= '0;
      resp_buf  <= '0;
      timer     <= '0;
      mem_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      // The CPU address is captured once; later changes while stalled are ignored.
      if (miss_detect) miss_addr <= bus.cpu_addr;
      if (resp_take)   resp_buf  <= bus.mem_resp_data;
      if (req_fire) begin
        timer <= '0;
      end else if (state == ST_WAIT) begin
        timer <= timer + TIMER_WIDTH'(1);
      end
      if (timeout_hit) mem_err <= 1'b1;
    end
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    bus.cache_addr    = miss_addr;
    bus.cpu_data      = '0;
    bus.stall         = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.fill_we       = 1'b0;
    bus.fill_data     = resp_buf;
    bus.mem_req_addr  = ADDR_WIDTH'(word_align(MAX_ADDR_WIDTH'(miss_addr)));
    case (state)
      ST_IDLE: begin
        bus.cache_addr = bus.cpu_addr;
        // Reset holds the CPU-visible outputs quiet even if a request is pending.
        if (rst_n) begin
          bus.cpu_data = bus.cache_data;
          bus.stall    = miss_detect;
        end
      end
      ST_REQ: begin
        bus.stall         = 1'b1;
        bus.mem_req_valid = 1'b1;
      end
      ST_WAIT: begin
        bus.stall = 1'b1;
      end
      ST_FILL: begin
        bus.stall   = 1'b1;
        bus.fill_we = 1'b1;
      end
      default: begin
        bus.stall = 1'b0;
      end
    endcase
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss_detect),
    .count (miss_count)
  );

endmodule
